// File: rtl/param_fifo_buffer_if.sv
// Producer/consumer bundle for param_fifo_buffer: write, read and status signals.
// The master drives the requests, and the slave (the FIFO) drives the read data and the status.
interface param_fifo_buffer_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  // Handshake: a write is taken on an edge with wr_en high while not full (or with rd_en
  // also high); a read is taken with rd_en high while not empty, and its data appears one
  // cycle later, qualified by a one-cycle rd_valid. flush beats both requests.
  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/param_fifo_buffer.sv
// Parametrised single-clock FIFO with a registered read port, almost flags, flush and
// one-cycle overflow/underflow pulses.
module param_fifo_buffer #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  param_fifo_buffer_if.slave    bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty;
  logic wr_accept, rd_accept;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // A full FIFO still takes a write when a read frees the oldest slot on the same edge.
  assign wr_accept = bus.wr_en && (!full || bus.rd_en) && !bus.flush;
  assign rd_accept = bus.rd_en && !empty && !bus.flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_accept) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (rd_accept) begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(1);
        rd_data_d  = mem_q[rd_ptr_q];
        rd_valid_d = 1'b1;
      end
      count_d     = count_q + CNT_W'(wr_accept) - CNT_W'(rd_accept);
      overflow_d  = bus.wr_en && !wr_accept;
      underflow_d = bus.rd_en && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // The storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) mem_q[wr_ptr_q] <= bus.wr_data;
  end

  assign bus.rd_data      = rd_data_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (int'(count_q) >= AF_THRESH);
  assign bus.almost_empty = (int'(count_q) <= AE_THRESH);
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
